// File: rtl/flow_arb_pkg.sv
// Shared types and sizing helpers for the flow-table memory arbiter.
package flow_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } arb_state_t;

    // Watchdog counter width; TIMEOUT_CYC must fit in this many bits.
    localparam int WDOG_W = 16;

    function automatic int arb_idx_w(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/flow_mem_arbiter_pick.sv
// Combinational round-robin picker for the flow-table memory arbiter.
// With ARB_CTRL_PRIO_EN defined, requester 0 overrides the round-robin scan.
module rr_arb_pick #(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any_valid
);

    logic [NUM_REQ-1:0] rr_req;
    logic [IDX_W-1:0]   cand;
    logic [IDX_W-1:0]   rr_idx;
    logic               rr_found;

`ifdef ARB_CTRL_PRIO_EN
    assign rr_req    = req & {{(NUM_REQ-1){1'b1}}, 1'b0};
    assign any_valid = req[0] | rr_found;
`else
    assign rr_req    = req;
    assign any_valid = rr_found;
`endif

    // NOTE: every variable written here gets a default first, otherwise the
    // paths that skip an assignment would infer a latch.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!rr_found && rr_req[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    always_comb begin
        idx   = rr_idx;
`ifdef ARB_CTRL_PRIO_EN
        if (req[0]) idx = '0;
`endif
        grant = '0;
        if (any_valid) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/flow_mem_arbiter.sv
// Shares the single flow-table memory port among NUM_REQ requesters, one
// transaction in flight, with a watchdog. Option macro: ARB_CTRL_PRIO_EN.
module flow_mem_arbiter
    import flow_arb_pkg::*;
#(
    parameter int NUM_REQ     = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_ce_i,
    input  logic [NUM_REQ-1:0]        req_we_i,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [DATA_W-1:0]         req_data_o,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic                      mem_ce_o,
    output logic                      mem_we_o,
    output logic [ADDR_W-1:0]         mem_addr_o,
    output logic [DATA_W-1:0]         mem_data_o,
    input  logic [DATA_W-1:0]         mem_data_i,
    input  logic                      mem_ack_i,
    output logic                      arb_timeout_o
);

    localparam int IDX_W = arb_idx_w(NUM_REQ);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYC - 1);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    ptr_q, ptr_next;
    logic [IDX_W-1:0]    idx_q;
    logic                we_q;
    logic [WDOG_W-1:0]   wdog_q;

    logic [NUM_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;
    logic                grant_now, ack_now, timeout_now;

    logic [ADDR_W-1:0]   addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   data_arr [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            addr_arr[k] = req_addr_i[k*ADDR_W +: ADDR_W];
            data_arr[k] = req_data_i[k*DATA_W +: DATA_W];
        end
    end

    rr_arb_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req       (req_ce_i),
        .ptr       (ptr_q),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any_valid (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        grant_now   = 1'b0;
        ack_now     = 1'b0;
        timeout_now = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_now = 1'b1;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                // An ack coinciding with the strobe completes the transaction.
                if (mem_ack_i) begin
                    ack_now = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (mem_ack_i) begin
                    ack_now = 1'b1;
                    state_d = DONE;
                end else if (wdog_q == WDOG_LAST) begin
                    timeout_now = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef ARB_CTRL_PRIO_EN
    assign ptr_next = (idx_q == '0) ? ptr_q :
                      (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
`else
    assign ptr_next = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q         <= '0;
            idx_q         <= '0;
            we_q          <= 1'b0;
            wdog_q        <= '0;
            req_ready_o   <= '1;
            req_data_o    <= '0;
            mem_ce_o      <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_data_o    <= '0;
            arb_timeout_o <= 1'b0;
        end else begin
            mem_ce_o      <= grant_now;
            arb_timeout_o <= timeout_now;

            if (grant_now) begin
                idx_q       <= pick_idx;
                we_q        <= req_we_i[pick_idx];
                mem_we_o    <= req_we_i[pick_idx];
                mem_addr_o  <= addr_arr[pick_idx];
                mem_data_o  <= data_arr[pick_idx];
                req_ready_o <= req_ready_o & ~pick_grant;
            end

            if (state_q == ISSUE)     wdog_q <= '0;
            else if (state_q == WAIT) wdog_q <= wdog_q + 1'b1;

            if (ack_now && !we_q) req_data_o <= mem_data_i;
            if (timeout_now)      req_data_o <= '0;

            if (state_q == DONE) begin
                req_ready_o[idx_q] <= 1'b1;
                ptr_q              <= ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_flow_mem_arbiter.sv
// Scoreboard bench for flow_mem_arbiter: stimulus pushes expectations,
// a negedge monitor pops them on memory strobes and ready rises.
module tb_flow_mem_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [N-1:0]    req_ce = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [DW-1:0]   req_data_o;
    logic [N-1:0]    req_ready_o;
    logic            mem_ce_o, mem_we_o, arb_timeout_o;
    logic [AW-1:0]   mem_addr_o;
    logic [DW-1:0]   mem_data_o;
    logic [DW-1:0]   mem_data_i;
    logic            mem_ack_i;

    logic            mem_ack = 1'b0;
    logic [DW-1:0]   mem_rdata = '0;
    logic            man_ack = 1'b0;
    logic [DW-1:0]   man_data = '0;
    logic            mem_mute = 1'b0;
    logic            mon_en = 1'b0;

    assign mem_ack_i  = mem_ack | man_ack;
    assign mem_data_i = man_ack ? man_data : mem_rdata;

    flow_mem_arbiter #(
        .NUM_REQ     (N),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_ce_i      (req_ce),
        .req_we_i      (req_we),
        .req_addr_i    (req_addr),
        .req_data_i    (req_wdata),
        .req_data_o    (req_data_o),
        .req_ready_o   (req_ready_o),
        .mem_ce_o      (mem_ce_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_data_o    (mem_data_o),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .arb_timeout_o (arb_timeout_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_exp_t;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic        to;
    } rsp_exp_t;

    mem_exp_t    mem_q[$];
    rsp_exp_t    rsp_q[$];
    logic [31:0] last_rd = '0;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] raddr(input int k);
        return 32'h0020_0000 + 32'(k * 16);
    endfunction

    function automatic logic [31:0] rdat(input int k);
        return 32'h5500_0000 + 32'(k);
    endfunction

    task automatic set_port(input int k, input logic we, input logic [31:0] a, input logic [31:0] d);
        req_we[k]            = we;
        req_addr[k*AW +: AW] = a;
        req_wdata[k*DW +: DW] = d;
    endtask

    task automatic push_read(input int k);
        mem_q.push_back('{idx: k, we: 1'b0, addr: raddr(k), data: rdat(k)});
        last_rd = 32'hA0 + 32'(k);
        rsp_q.push_back('{idx: k, data: last_rd, to: 1'b0});
    endtask

    task automatic push_write(input int k, input logic [31:0] a, input logic [31:0] d);
        mem_q.push_back('{idx: k, we: 1'b1, addr: a, data: d});
        rsp_q.push_back('{idx: k, data: last_rd, to: 1'b0});
    endtask

    task automatic wait_ready(input int k, input logic val);
        int c = 0;
        while (req_ready_o[k] !== val && c < 200) begin
            @(negedge clk);
            c++;
        end
        check($sformatf("wait_ready%0d_%0b", k, val), 64'(req_ready_o[k]), 64'(val));
    endtask

    task automatic wait_idle();
        int c = 0;
        while (req_ready_o !== '1 && c < 200) begin
            @(negedge clk);
            c++;
        end
        check("wait_idle", 64'(req_ready_o), 64'(3'b111));
        repeat (2) @(negedge clk);
    endtask

    // Raise ce on every port with a nonzero quota; drop each once it has
    // been granted its quota of reads.
    task automatic run_quota(input int q0, input int q1, input int q2);
        int quota[N];
        int got[N];
        int total = 0;
        int need;
        quota = '{q0, q1, q2};
        need  = q0 + q1 + q2;
        for (int k = 0; k < N; k++) begin
            got[k] = 0;
            if (quota[k] > 0) begin
                set_port(k, 1'b0, raddr(k), rdat(k));
                req_ce[k] = 1'b1;
            end
        end
        for (int c = 0; c < 400 && total < need; c++) begin
            @(negedge clk);
            if (mem_ce_o) begin
                for (int k = 0; k < N; k++) begin
                    if (!req_ready_o[k]) begin
                        got[k]++;
                        total++;
                        if (got[k] >= quota[k]) req_ce[k] = 1'b0;
                    end
                end
            end
        end
        req_ce = '0;
        check("quota_grants", 64'(total), 64'(need));
    endtask

    // Memory model: ack two cycles after the strobe cycle.
    logic [31:0] rd_addr;
    logic        rd_we;
    initial begin
        forever begin
            @(negedge clk);
            if (rst && mem_ce_o && !mem_mute) begin
                rd_addr = mem_addr_o;
                rd_we   = mem_we_o;
                repeat (2) @(posedge clk);
                #1;
                mem_ack   = 1'b1;
                mem_rdata = rd_we ? 32'hFFFF_FFFF : 32'hA0 + 32'(rd_addr[7:4]);
                @(posedge clk);
                #1;
                mem_ack   = 1'b0;
                mem_rdata = '0;
            end
        end
    end

    // Monitor / scoreboard.
    logic [N-1:0] prev_ready = '1;
    logic         prev_to    = 1'b0;
    int           strobe_cyc = 0;
    mem_exp_t     me;
    rsp_exp_t     re;
    always @(negedge clk) begin
        if (mon_en && rst) begin
            if (mem_ce_o) begin
                strobe_cyc = cyc;
                if (mem_q.size() == 0) begin
                    check("unexpected_strobe", 64'(mem_addr_o), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    me = mem_q.pop_front();
                    check("strobe_we",    64'(mem_we_o),   64'(me.we));
                    check("strobe_addr",  64'(mem_addr_o), 64'(me.addr));
                    check("strobe_data",  64'(mem_data_o), 64'(me.data));
                    check("strobe_ready", 64'(req_ready_o), 64'(3'b111 & ~(3'b001 << me.idx)));
                end
            end
            if (arb_timeout_o)
                check("timeout_delay", 64'(cyc - strobe_cyc), 64'(TO + 1));
            for (int k = 0; k < N; k++) begin
                if (req_ready_o[k] && !prev_ready[k]) begin
                    if (rsp_q.size() == 0) begin
                        check("unexpected_ready_rise", 64'(k), 64'hFF);
                    end else begin
                        re = rsp_q.pop_front();
                        check("rsp_port",    64'(k),          64'(re.idx));
                        check("rsp_data",    64'(req_data_o), 64'(re.data));
                        check("rsp_timeout", 64'(prev_to),    64'(re.to));
                    end
                end
            end
        end
        prev_ready = req_ready_o;
        prev_to    = arb_timeout_o;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time budget");
        $fatal(1, "global timeout");
    end

    logic [31:0] b2b_data [4];
    initial begin
        b2b_data = '{32'h0100b7ac, 32'hf62c0000, 32'habcdef01, 32'h23450001};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_ready",   64'(req_ready_o),   64'(3'b111));
        check("rst_mem_ce",  64'(mem_ce_o),      64'd0);
        check("rst_mem_we",  64'(mem_we_o),      64'd0);
        check("rst_addr",    64'(mem_addr_o),    64'd0);
        check("rst_wdata",   64'(mem_data_o),    64'd0);
        check("rst_rdata",   64'(req_data_o),    64'd0);
        check("rst_timeout", 64'(arb_timeout_o), 64'd0);
        mon_en = 1'b1;

        // Contention: all three request reads, port 0 wants two.
`ifdef ARB_CTRL_PRIO_EN
        push_read(0); push_read(0); push_read(1); push_read(2);
`else
        push_read(0); push_read(1); push_read(2); push_read(0);
`endif
        run_quota(2, 1, 1);
        wait_idle();

        // Single write on port 0.
        set_port(0, 1'b1, 32'h0010_0880, 32'h0100b7ac);
        push_write(0, 32'h0010_0880, 32'h0100b7ac);
        req_ce[0] = 1'b1;
        wait_ready(0, 1'b0);
        req_ce[0] = 1'b0;
        wait_ready(0, 1'b1);
        wait_idle();

        // Back-to-back writes with ce held; next vector loaded once ready rises.
        for (int n = 0; n < 4; n++)
            push_write(0, 32'h0010_0880 + 32'(4 * n), b2b_data[n]);
        set_port(0, 1'b1, 32'h0010_0880, b2b_data[0]);
        req_ce[0] = 1'b1;
        for (int n = 0; n < 4; n++) begin
            wait_ready(0, 1'b0);
            if (n == 3) begin
                req_ce[0] = 1'b0;
            end else begin
                wait_ready(0, 1'b1);
                set_port(0, 1'b1, 32'h0010_0880 + 32'(4 * (n + 1)), b2b_data[n + 1]);
            end
        end
        wait_idle();

        // Timeout on port 1: memory never acks.
        mem_q.push_back('{idx: 1, we: 1'b0, addr: raddr(1), data: rdat(1)});
        last_rd = '0;
        rsp_q.push_back('{idx: 1, data: 32'h0, to: 1'b1});
        mem_mute = 1'b1;
        set_port(1, 1'b0, raddr(1), rdat(1));
        req_ce[1] = 1'b1;
        wait_ready(1, 1'b0);
        req_ce[1] = 1'b0;
        wait_ready(1, 1'b1);
        mem_mute = 1'b0;
        wait_idle();

        // Next request after a timeout is served normally.
        push_read(0);
        run_quota(1, 0, 0);
        wait_idle();

        // Reset while port 2 waits; a late ack must be ignored.
        mem_q.push_back('{idx: 2, we: 1'b0, addr: raddr(2), data: rdat(2)});
        mem_mute = 1'b1;
        set_port(2, 1'b0, raddr(2), rdat(2));
        req_ce[2] = 1'b1;
        wait_ready(2, 1'b0);
        req_ce[2] = 1'b0;
        repeat (4) @(negedge clk);
        mon_en = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        man_data = 32'hDEAD_BEEF;
        man_ack  = 1'b1;
        @(negedge clk);
        man_ack  = 1'b0;
        mem_mute = 1'b0;
        check("midrst_ready",   64'(req_ready_o),   64'(3'b111));
        check("midrst_rdata",   64'(req_data_o),    64'd0);
        check("midrst_mem_ce",  64'(mem_ce_o),      64'd0);
        check("midrst_timeout", 64'(arb_timeout_o), 64'd0);
        repeat (2) @(negedge clk);
        check("midrst_rdata_hold", 64'(req_data_o), 64'd0);
        mon_en = 1'b1;

        // Pointer back at 0 after reset: order 0,1,2.
        push_read(0); push_read(1); push_read(2);
        run_quota(1, 1, 1);
        wait_idle();

        for (int c = 0; c < 100 && (mem_q.size() != 0 || rsp_q.size() != 0); c++)
            @(negedge clk);
        check("mem_queue_empty", 64'(mem_q.size()), 64'd0);
        check("rsp_queue_empty", 64'(rsp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
